decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter INSN_W, default 32, instruction width; field positions are fixed for 32.
REQ-002 Parameter DATA_W, default 32, width of the sign-extended immediate.
REQ-003 Parameter PC_W, default 12, width of the PC carried alongside the instruction.
REQ-004 Parameter DEPTH, default 2, output buffer entries; legal values are 2 to 8.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 Port: clock, in, 1, rising-edge clock.
REQ-007 Port: reset, in, 1, asynchronous active-low reset.
REQ-008 Port: flush, in, 1, synchronous discard of all buffered entries.
REQ-009 Port: in_valid, in, 1, upstream instruction present.
REQ-010 Port: in_ready, out, 1, buffer can accept; driven from a register.
REQ-011 Port: in_insn, in, INSN_W, raw instruction.
REQ-012 Port: in_pc, in, PC_W, instruction PC.
REQ-013 Port: out_valid, in_ready/out_ready pair as below; out_valid, out, 1, head entry valid.
REQ-014 Port: out_ready, in, 1, downstream accepts the head entry.
REQ-015 Port: out_pc, out, PC_W, PC of the head entry.
REQ-016 Port: out_opcode, out_rd, out_rs, out_rt, out_shamt, out_aluop, out, 5 each, fields of the head entry.
REQ-017 Port: out_imm, out, DATA_W, [16:0] sign-extended.
REQ-018 Port: out_target, out, 27, [26:0] zero-extended.
REQ-019 Port: out_ctrl, out, 12, one-hot class flags: {illegal, setx, bex, blt, jr, jal, bne, j, lw, sw, addi, alu_r}.
REQ-020 Port: illegal_seen, out, 1, sticky flag set by any accepted illegal instruction.

Function
REQ-021 Field extraction SHALL be: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], aluop [6:2].
REQ-022 Opcode decoding SHALL be: alu_r 00000, j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000, setx 10101, bex 10110.
REQ-023 Any other opcode SHALL set only illegal, as SHALL opcode 00000 with aluop greater than 00111.
REQ-024 Exactly one out_ctrl bit SHALL be set whenever out_valid is 1.
REQ-025 Decoding SHALL happen at accept time; the buffer stores the decoded fields, not raw instruction bits.
REQ-026 An accept SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-027 Latency SHALL be 1 cycle: an entry accepted at edge N is visible at the head after edge N when the buffer was empty.
REQ-028 Throughput SHALL be 1 instruction per cycle, with accept and pop allowed in the same cycle.
REQ-029 The buffer SHALL be a circular FIFO of DEPTH entries with read and write pointers that wrap from DEPTH-1 to 0.
REQ-030 A count register SHALL track occupancy.
REQ-031 in_ready SHALL be registered: it equals (count_next < DEPTH).
REQ-032 When the buffer is full and a pop occurs, in_ready SHALL rise one cycle later; no combinational path from out_ready to in_ready is allowed.
REQ-033 out_valid SHALL equal (count != 0).
REQ-034 All out_* data SHALL be held stable while out_valid is 1 and out_ready is 0.
REQ-035 flush SHALL take priority: pointers and count go to 0 and out_valid goes to 0 next cycle.
REQ-036 Any accept or pop in the flush cycle SHALL be discarded, and in_ready SHALL be 1 next cycle.
REQ-037 illegal_seen SHALL be set on the accept of an illegal instruction and SHALL be cleared only by reset; flush does not clear it.

Reset
REQ-038 While reset is 0, pointers, count, out_valid, and illegal_seen SHALL be 0, and in_ready SHALL be 0.
REQ-039 in_ready SHALL rise at the first clock edge after reset is released.
REQ-040 Buffer data need not be reset, but all out_* data SHALL read 0 while out_valid is 0.
REQ-041 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-042 The opcode constants, aluop limit, out_ctrl bit indices, and the field-position constants SHALL live in shared package proc_pkg.
REQ-043 Combinational decode SHALL be the sub-module insn_field_decode, taking the instruction and returning all fields, imm, target, and out_ctrl.
REQ-044 decode_stage SHALL instantiate insn_field_decode once and own only the FIFO and the handshake.

Verification
REQ-045 Reset then addi (opcode 00101, rd=3, rs=1, imm=0x1FFFF) -> next cycle out_valid=1, out_ctrl=addi, out_imm=0xFFFFFFFF.
REQ-046 Hold out_ready=0 and push 3 instructions with DEPTH=2 -> the third is not accepted, in_ready=0, and the head is unchanged.
REQ-047 Then set out_ready=1 for 1 cycle -> the first entry pops, in_ready=1 next cycle, and the third is accepted.
REQ-048 Continuous in_valid and out_ready=1 with 8 instructions -> 8 outputs in order on consecutive cycles and the pointers wrap.
REQ-049 Opcode 11111, then aluop 01000 with opcode 0 -> out_ctrl=illegal for both, and illegal_seen=1 stays set after flush.
REQ-050 flush while full with an accept -> out_valid=0 next cycle, count=0, and the accepted instruction never appears.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: instruction field positions, opcode constants and out_ctrl bit
// indices shared by the decoder and the decode stage.
package proc_pkg;
   localparam int OPC_HI = 31, OPC_LO = 27;
   localparam int RD_HI  = 26, RD_LO  = 22;
   localparam int RS_HI  = 21, RS_LO  = 17;
   localparam int RT_HI  = 16, RT_LO  = 12;
   localparam int SH_HI  = 11, SH_LO  = 7;
   localparam int ALU_HI = 6,  ALU_LO = 2;
   localparam int IMM_HI = 16, TGT_HI = 26;
   localparam logic [4:0] OP_ALU  = 5'b00000, OP_J    = 5'b00001, OP_BNE = 5'b00010,
                          OP_JAL  = 5'b00011, OP_JR   = 5'b00100, OP_ADDI = 5'b00101,
                          OP_BLT  = 5'b00110, OP_SW   = 5'b00111, OP_LW  = 5'b01000,
                          OP_SETX = 5'b10101, OP_BEX  = 5'b10110;
   localparam logic [4:0] ALUOP_MAX = 5'b00111;
   localparam int C_ALU_R = 0, C_ADDI = 1, C_SW = 2, C_LW = 3, C_J = 4, C_BNE = 5,
                  C_JAL = 6, C_JR = 7, C_BLT = 8, C_BEX = 9, C_SETX = 10, C_ILLEGAL = 11;
   localparam int CTRL_W = 12;
   typedef struct packed {
      logic [4:0]        opcode, rd, rs, rt, shamt, aluop;
      logic [26:0]       target;
      logic [CTRL_W-1:0] ctrl;
   } dec_t;
endpackage

// File: rtl/insn_field_decode.sv
// insn_field_decode: purely combinational split of a raw instruction into
// its fields, sign-extended immediate, jump target and one-hot class.
module insn_field_decode
   import proc_pkg::*;
#(
   parameter int INSN_W = 32,
   parameter int DATA_W = 32
) (
   input  logic [INSN_W-1:0] insn_i,
   output dec_t              dec_o,
   output logic [DATA_W-1:0] imm_o
);
   logic [CTRL_W-1:0] ctrl;

   always_comb begin
      ctrl = '0;
      case (insn_i[OPC_HI:OPC_LO])
         OP_ALU:  ctrl[insn_i[ALU_HI:ALU_LO] > ALUOP_MAX ? C_ILLEGAL : C_ALU_R] = 1'b1;
         OP_J:    ctrl[C_J]    = 1'b1;
         OP_BNE:  ctrl[C_BNE]  = 1'b1;
         OP_JAL:  ctrl[C_JAL]  = 1'b1;
         OP_JR:   ctrl[C_JR]   = 1'b1;
         OP_ADDI: ctrl[C_ADDI] = 1'b1;
         OP_BLT:  ctrl[C_BLT]  = 1'b1;
         OP_SW:   ctrl[C_SW]   = 1'b1;
         OP_LW:   ctrl[C_LW]   = 1'b1;
         OP_SETX: ctrl[C_SETX] = 1'b1;
         OP_BEX:  ctrl[C_BEX]  = 1'b1;
         default: ctrl[C_ILLEGAL] = 1'b1;
      endcase
   end

   assign dec_o = '{opcode: insn_i[OPC_HI:OPC_LO], rd: insn_i[RD_HI:RD_LO],
                    rs: insn_i[RS_HI:RS_LO], rt: insn_i[RT_HI:RT_LO],
                    shamt: insn_i[SH_HI:SH_LO], aluop: insn_i[ALU_HI:ALU_LO],
                    target: insn_i[TGT_HI:0], ctrl: ctrl};
   assign imm_o = {{(DATA_W-IMM_HI-1){insn_i[IMM_HI]}}, insn_i[IMM_HI:0]};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes instructions on accept and buffers the decoded
// entries in a small circular FIFO with a registered in_ready.
module decode_stage
   import proc_pkg::*;
#(
   parameter int INSN_W = 32,
   parameter int DATA_W = 32,
   parameter int PC_W   = 12,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [INSN_W-1:0] in_insn_i,
   input  logic [PC_W-1:0]   in_pc_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [PC_W-1:0]   out_pc_o,
   output logic [4:0]        out_opcode_o,
   output logic [4:0]        out_rd_o,
   output logic [4:0]        out_rs_o,
   output logic [4:0]        out_rt_o,
   output logic [4:0]        out_shamt_o,
   output logic [4:0]        out_aluop_o,
   output logic [DATA_W-1:0] out_imm_o,
   output logic [26:0]       out_target_o,
   output logic [11:0]       out_ctrl_o,
   output logic              illegal_seen_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   dec_t              dec, head;
   logic [DATA_W-1:0] dec_imm;
   dec_t              dec_mem [DEPTH];
   logic [DATA_W-1:0] imm_mem [DEPTH];
   logic [PC_W-1:0]   pc_mem  [DEPTH];
   logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rdy_q, ill_q, acc, pop;

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   insn_field_decode #(.INSN_W(INSN_W), .DATA_W(DATA_W)) u_dec (
      .insn_i(in_insn_i),
      .dec_o (dec),
      .imm_o (dec_imm)
   );

   // flush cancels any same-cycle accept or pop
   assign acc   = in_valid_i & rdy_q & ~flush_i;
   assign pop   = out_valid_o & out_ready_i & ~flush_i;
   assign wr_d  = flush_i ? '0 : acc ? nxt(wr_q) : wr_q;
   assign rd_d  = flush_i ? '0 : pop ? nxt(rd_q) : rd_q;
   assign cnt_d = flush_i ? '0 : cnt_q + CNT_W'(acc) - CNT_W'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         rdy_q <= 1'b0;
         ill_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         rdy_q <= cnt_d < CNT_W'(DEPTH);
         ill_q <= ill_q | (acc & dec.ctrl[C_ILLEGAL]);
      end
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         dec_mem[wr_q] <= dec;
         imm_mem[wr_q] <= dec_imm;
         pc_mem[wr_q]  <= in_pc_i;
      end
   end

   assign out_valid_o    = cnt_q != '0;
   assign in_ready_o     = rdy_q;
   assign illegal_seen_o = ill_q;
   assign head           = out_valid_o ? dec_mem[rd_q] : '0;
   assign out_imm_o      = out_valid_o ? imm_mem[rd_q] : '0;
   assign out_pc_o       = out_valid_o ? pc_mem[rd_q] : '0;
   assign out_opcode_o   = head.opcode;
   assign out_rd_o       = head.rd;
   assign out_rs_o       = head.rs;
   assign out_rt_o       = head.rt;
   assign out_shamt_o    = head.shamt;
   assign out_aluop_o    = head.aluop;
   assign out_target_o   = head.target;
   assign out_ctrl_o     = head.ctrl;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus against a queue-based
// reference model of the decode buffer.
module tb_decode_stage;
   localparam int DEPTH = 2;

   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_insn = '0;
   logic [11:0] in_pc = '0;
   logic        in_ready, out_valid, illegal_seen;
   logic [11:0] out_pc, out_ctrl;
   logic [4:0]  out_opcode, out_rd, out_rs, out_rt, out_shamt, out_aluop;
   logic [31:0] out_imm;
   logic [26:0] out_target;

   typedef struct {
      logic [31:0] insn;
      logic [11:0] pc;
   } ent_t;

   ent_t q[$];
   logic rdy_m = 1'b0, ill_m = 1'b0;
   int   total = 0, bad = 0;
   logic [4:0] legal_ops [11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22};

   decode_stage #(.INSN_W(32), .DATA_W(32), .PC_W(12), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_insn_i(in_insn), .in_pc_i(in_pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_pc_o(out_pc), .out_opcode_o(out_opcode), .out_rd_o(out_rd), .out_rs_o(out_rs),
      .out_rt_o(out_rt), .out_shamt_o(out_shamt), .out_aluop_o(out_aluop), .out_imm_o(out_imm),
      .out_target_o(out_target), .out_ctrl_o(out_ctrl), .illegal_seen_o(illegal_seen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // class index in {illegal..alu_r} order, from the opcode table
   function automatic int class_of(input logic [31:0] i);
      int op = int'((i >> 27) & 31), aop = int'((i >> 2) & 31);
      case (op)
         0: return aop > 7 ? 11 : 0;
         1: return 4;
         2: return 5;
         3: return 6;
         4: return 7;
         5: return 1;
         6: return 8;
         7: return 2;
         8: return 3;
         21: return 10;
         22: return 9;
         default: return 11;
      endcase
   endfunction

   task automatic check_outputs();
      logic        v = q.size() != 0;
      logic [31:0] i = v ? q[0].insn : 32'd0;
      chk("in_ready", in_ready, rdy_m);
      chk("out_valid", out_valid, v);
      chk("illegal_seen", illegal_seen, ill_m);
      chk("pc", out_pc, v ? q[0].pc : 12'd0);
      chk("opcode", out_opcode, (i >> 27) & 31);
      chk("rd", out_rd, (i >> 22) & 31);
      chk("rs", out_rs, (i >> 17) & 31);
      chk("rt", out_rt, (i >> 12) & 31);
      chk("shamt", out_shamt, (i >> 7) & 31);
      chk("aluop", out_aluop, (i >> 2) & 31);
      chk("imm", out_imm, v ? 32'($signed(i[16:0])) : 32'd0);
      chk("target", out_target, i % (1 << 27));
      chk("ctrl", out_ctrl, v ? 64'(1) << class_of(i) : 64'd0);
   endtask

   task automatic step();
      ent_t e;
      logic acc, pop;
      @(posedge clk);
      acc = in_valid && rdy_m;
      pop = q.size() != 0 && out_ready;
      e.insn = in_insn;
      e.pc   = in_pc;
      if (flush) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (acc) begin
            q.push_back(e);
            if (class_of(e.insn) == 11) ill_m = 1'b1;
         end
      end
      rdy_m = q.size() < DEPTH;
      #1;
      check_outputs();
   endtask

   function automatic logic [31:0] rand_insn();
      logic [31:0] i = $urandom;
      if ($urandom_range(0, 3) != 0) i[31:27] = legal_ops[$urandom_range(0, 10)];
      return i;
   endfunction

   task automatic drive(input logic v, input logic [31:0] i, input logic r, input logic f);
      in_valid  = v;
      in_insn   = i;
      in_pc     = 12'($urandom);
      out_ready = r;
      flush     = f;
   endtask

   initial begin
      #12;
      check_outputs();
      chk("reset_ready", in_ready, 1'b0);
      rst_n = 1'b1;
      drive(1'b1, {5'b00101, 5'd3, 5'd1, 17'h1FFFF}, 1'b0, 1'b0);
      step();
      step();
      chk("addi_valid", out_valid, 1'b1);
      chk("addi_ctrl", out_ctrl, 12'h002);
      chk("addi_imm", out_imm, 32'hFFFFFFFF);
      drive(1'b1, rand_insn(), 1'b0, 1'b0);
      step();
      drive(1'b1, rand_insn(), 1'b0, 1'b0);
      step();
      chk("full_not_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("ready_after_pop", in_ready, 1'b1);
      step();
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      repeat (3) step();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, rand_insn(), 1'b1, 1'b0);
         step();
      end
      in_valid = 1'b0;
      step();
      drive(1'b1, 32'hF800_0000 | 32'($urandom_range(0, 32'h07FF_FFFF)), 1'b1, 1'b0);
      step();
      chk("illegal_op", out_ctrl, 12'h800);
      drive(1'b1, 32'h0000_0020, 1'b1, 1'b0);
      step();
      chk("illegal_aluop", out_ctrl, 12'h800);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      step();
      chk("sticky_after_flush", illegal_seen, 1'b1);
      drive(1'b1, rand_insn(), 1'b0, 1'b0);
      repeat (2) step();
      drive(1'b1, rand_insn(), 1'b1, 1'b1);
      step();
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_ready", in_ready, 1'b1);
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      step();
      chk("flush_discard", out_valid, 1'b0);
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 3) != 0, rand_insn(), $urandom_range(0, 2) != 0,
               $urandom_range(0, 24) == 0);
         step();
         if (out_valid) chk("one_hot", 64'($countones(out_ctrl)), 64'd1);
      end
      drive(1'b1, rand_insn(), 1'b0, 1'b0);
      repeat (2) step();
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      rdy_m = 1'b0;
      ill_m = 1'b0;
      chk("async_reset_valid", out_valid, 1'b0);
      check_outputs();
      #3 rst_n = 1'b1;
      step();
      chk("ready_after_reset", in_ready, 1'b1);
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
